// File: rtl/timer_dev.sv
// +----------------------------------------------------------------------------+
// | Module      : timer_dev                                                    |
// | Description : Memory-mapped countdown timer with CTRL/PRESET/COUNT regs,   |
// |               one-shot and auto-reload modes, level IRQ.                   |
// | Option      : TIMER_COUNT_WRITE_EN enables software writes to COUNT.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module timer_dev #(
  parameter logic [31:0] RST_PRESET = 32'h0000_0000,
  parameter int          ADDR_LSB   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_ctrl, w_ctrl_nxt;
  logic [31:0] r_preset, w_preset_nxt;
  logic [31:0] r_count, w_count_nxt;
  logic        r_irq, w_irq_nxt;
  logic [1:0]  w_sel;
  logic        w_unused_addr;

  assign w_sel         = Addr[ADDR_LSB+1:ADDR_LSB];
  assign w_unused_addr = ^Addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_ctrl   <= 4'h0;
      r_preset <= RST_PRESET;
      r_count  <= 32'h0;
      r_irq    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ctrl   <= w_ctrl_nxt;
      r_preset <= w_preset_nxt;
      r_count  <= w_count_nxt;
      r_irq    <= w_irq_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_ctrl_nxt   = r_ctrl;
    w_preset_nxt = r_preset;
    w_count_nxt  = r_count;
    w_irq_nxt    = r_irq;

    case (r_state)
      S_IDLE: begin
        if (r_ctrl[0]) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_count_nxt = r_preset;
        w_irq_nxt   = 1'b0;
        w_state_nxt = r_ctrl[0] ? S_CNT : S_IDLE;
      end
      S_CNT: begin
        if (!r_ctrl[0]) begin
          w_state_nxt = S_IDLE;
        end else if (r_count > 32'd1) begin
          w_count_nxt = r_count - 32'd1;
        end else begin
          w_count_nxt = 32'h0;
          w_irq_nxt   = 1'b1;
          w_state_nxt = S_INT;
        end
      end
      default: begin
        // Auto-reload restarts through IDLE (EN still set), giving a P+3 period
        w_state_nxt = S_IDLE;
        if (r_ctrl[2:1] == 2'b01) w_irq_nxt = 1'b0;
        else                      w_ctrl_nxt[0] = 1'b0;
      end
    endcase

    // Software writes take priority over the FSM updates above
    if (WE) begin
      case (w_sel)
        2'd0: begin
          w_ctrl_nxt = Din[3:0];
          w_irq_nxt  = 1'b0;
        end
        2'd1: begin
          w_preset_nxt = Din;
          w_irq_nxt    = 1'b0;
        end
`ifdef TIMER_COUNT_WRITE_EN
        2'd2: begin
          w_count_nxt = Din;
          if (r_state == S_CNT && r_ctrl[0]) begin
            w_state_nxt = S_CNT;
            w_irq_nxt   = r_irq;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    case (w_sel)
      2'd0:    Dout = {28'h0, r_ctrl};
      2'd1:    Dout = r_preset;
      2'd2:    Dout = r_count;
      default: Dout = 32'h0;
    endcase
  end

  assign IRQ = r_irq & r_ctrl[3];

endmodule

`default_nettype wire
